wrf_nibble_mux_arb: RTL and testbench
=====================================

// Module: wrf_nibble_mux_arb
// PURPOSE
//  Two-requester arbiter/sequencer for the shared 4-bit nibble 2:1 mux in the CGA_WRF path.
//  - Grants one requester at a time and drives that mux's select.
//  - Bounds each ownership to a burst of beats and registers the selected nibble as a valid-qualified output.
//  - Sits between the WRF nibble sources and the register-file write staging logic.
// PARAMETERS
//  BURST    4   max beats per grant before forced re-arbitration (legal range 1..16)
//  CNT_W    4   beat counter width; must satisfy 2**CNT_W >= BURST
// PORTS
//  sysclk      in   1  system clock; all state changes on rising edge
//  sys_rst_n   in   1  asynchronous active-low reset
//  req0        in   1  requester 0 wants the mux (level; held while it has beats)
//  req1        in   1  requester 1 wants the mux
//  d0          in   4  requester 0 nibble (mux input 0)
//  d1          in   4  requester 1 nibble (mux input 1)
//  gnt0        out  1  requester 0 owns the mux (registered)
//  gnt1        out  1  requester 1 owns the mux (registered)
//  sel         out  1  mux select: 0 = d0, 1 = d1 (registered)
//  out_valid   out  1  out_data holds a transferred beat (one-cycle pulse per beat)
//  out_data    out  4  registered mux output
//  last_owner  out  1  owner of the most recently ended grant (round-robin pointer)
// BEHAVIOUR
//  Reset (async assert, sync-safe release; all values hold while sys_rst_n=0):
//  - gnt0=gnt1=0, sel=0, out_valid=0, out_data=4'h0, beat_cnt=0, state=IDLE.
//  - last_owner=1, so requester 0 wins the first contended arbitration.
//  FSM states: IDLE, OWN0, OWN1. Encoding is free; gnt0=(state==OWN0), gnt1=(state==OWN1).
//  IDLE:
//  - No req: stay in IDLE; sel holds its last value.
//  - Exactly one req: go to OWNx for that requester.
//  - Both reqs: go to OWN(~last_owner).
//  - Arbitration latency is 1 cycle: req at edge N gives gnt at edge N+1.
//  - sel is updated on the same edge as gnt, so sel always matches the owner when any gnt=1.
//  OWNx:
//  - A beat occurs in a cycle where gnt_x=1 and req_x=1.
//  - On a beat edge: out_data <= d_x, out_valid <= 1, beat_cnt++.
//  - On any non-beat edge: out_valid <= 0; out_data holds its value.
//  Leave OWNx for IDLE, with beat_cnt <= 0 and last_owner <= x, when either:
//  - req_x=0 (no beat that cycle), or
//  - a beat occurs with beat_cnt==BURST-1 (that beat is still transferred).
//  - There is never a direct OWN0->OWN1 transition; at least one IDLE cycle separates grants (mux settle).
//  - The non-owner's req is ignored while it is not granted; it must hold req until gnt.
//  Throughput: a full burst occupies BURST+1 cycles (1 IDLE + BURST beats).
//  BURST=1: every beat is followed by IDLE; two contending requesters alternate beats.
//  Reset mid-burst: grant is dropped immediately; beat_cnt is cleared; the partial beat is not output.
//  Requesters must not change d_x combinationally from gnt in the same cycle; d_x is sampled at the beat edge.
// CONFIGURATION
//  WRF_ARB_FIXED_PRIO_EN
//  - Defined: in IDLE with both reqs, requester 0 always wins; last_owner still updates, but only for observation.
//  - Not defined (default): round-robin via last_owner as above.
// TESTING
//  1. Hold reset 3 cycles with req0=req1=1 -> gnt0=gnt1=0, sel=0, out_valid=0, out_data=0, last_owner=1 throughout.
//  2. req0=1 only, d0=4'hA..4'hD over 4 beats, BURST=4:
//     -> gnt0 rises 1 cycle after req0; out_data A,B,C,D on 4 consecutive cycles with out_valid=1;
//     -> IDLE one cycle, then OWN0 again.
//  3. req0=req1=1 continuously, BURST=4:
//     -> OWN0 for 4 beats, IDLE 1 cycle, OWN1 (sel=1) for 4 beats, IDLE 1 cycle, OWN0 again; period 10 cycles.
//  4. Owner 0 drops req0 after 2 beats while req1=1 -> OWN0->IDLE; no beat in the drop cycle; last_owner=0;
//     -> next grant is gnt1 with sel=1.
//  5. Assert sys_rst_n=0 asynchronously mid-burst at beat 2 -> gnt/out_valid go to 0 without a clock edge;
//     -> after release, requester 0 is granted first.
//  6. With WRF_ARB_FIXED_PRIO_EN defined, as scenario 3 -> only gnt0 is ever asserted;
//     -> gnt1 is granted only after req0=0.

Source files
------------

// File: rtl/wrf_nibble_mux_arb_if.sv
// Request/data/grant bundle between the WRF nibble sources and the shared
// nibble mux arbiter. The master drives requests and nibbles; the slave (the arbiter) drives grants and output.
interface wrf_nibble_mux_arb_if;
  logic       req0;
  logic       req1;
  logic [3:0] d0;
  logic [3:0] d1;
  logic       gnt0;
  logic       gnt1;
  logic       sel;
  logic       out_valid;
  logic [3:0] out_data;
  logic       last_owner;

  modport master (
    output req0, req1, d0, d1,
    input  gnt0, gnt1, sel, out_valid, out_data, last_owner
  );

  modport slave (
    input  req0, req1, d0, d1,
    output gnt0, gnt1, sel, out_valid, out_data, last_owner
  );
endinterface

// File: rtl/wrf_nibble_mux_arb.sv
// Two-requester burst-bounded arbiter driving the shared CGA_WRF nibble 2:1 mux.
// Define WRF_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin.
module wrf_nibble_mux_arb #(
  parameter int BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic                 sysclk,
  input  logic                 sys_rst_n,
  wrf_nibble_mux_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  state_e           state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             sel_q;
  logic             out_valid_q;
  logic [3:0]       out_data_q;
  logic             last_owner_q;

  logic       prio_pick;
  logic       win_pick;
  logic       own_req;
  logic [3:0] own_d;

`ifdef WRF_ARB_FIXED_PRIO_EN
  assign prio_pick = 1'b0;
`else
  assign prio_pick = ~last_owner_q;
`endif

  // With both requesting the priority rule decides; otherwise the lone requester wins.
  assign win_pick = (bus.req0 && bus.req1) ? prio_pick : bus.req1;

  // sel always names the current owner while a grant is held.
  assign own_req = sel_q ? bus.req1 : bus.req0;
  assign own_d   = sel_q ? bus.d1   : bus.d0;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 4'h0;
      last_owner_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every branch read the pre-edge state,
      // so the default below is safely overridden by a later assignment on a beat.
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state_q    <= win_pick ? OWN1 : OWN0;
            gnt0_q     <= ~win_pick;
            gnt1_q     <= win_pick;
            sel_q      <= win_pick;
            beat_cnt_q <= '0;
          end
        end
        OWN0, OWN1: begin
          if (own_req) begin
            out_valid_q <= 1'b1;
            out_data_q  <= own_d;
          end
          if (!own_req || beat_cnt_q == LAST_BEAT) begin
            state_q      <= IDLE;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            beat_cnt_q   <= '0;
            last_owner_q <= sel_q;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.sel        = sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.last_owner = last_owner_q;

endmodule

// File: tb/tb_wrf_nibble_mux_arb.sv
// Randomized bench for wrf_nibble_mux_arb against a transaction-level owner/beat model.
// Honours WRF_ARB_FIXED_PRIO_EN the same way the design does.
module tb_wrf_nibble_mux_arb;

  localparam int BURST = 4;
`ifdef WRF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic sysclk = 1'b0;
  logic sys_rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  wrf_nibble_mux_arb_if bus ();

  wrf_nibble_mux_arb #(.BURST(BURST), .CNT_W(4)) dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: who owns the mux, how many beats it has had, and what was last shown.
  int         m_owner;   // -1 = nobody
  int         m_beats;
  bit         m_last;
  bit         m_sel;
  bit         m_vld;
  logic [3:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = 1'b1;
    m_sel   = 1'b0;
    m_vld   = 1'b0;
    m_data  = 4'h0;
  endtask

  // One clock edge worth of arbitration/transfer rules.
  task automatic model_step(input bit r0, input bit r1, input logic [3:0] a, input logic [3:0] b);
    bit rx;
    if (m_owner < 0) begin
      m_vld = 1'b0;
      if (r0 || r1) begin
        if (r0 && r1) m_owner = FIXED ? 0 : (m_last ? 0 : 1);
        else          m_owner = r1 ? 1 : 0;
        m_sel   = (m_owner == 1);
        m_beats = 0;
      end
    end else begin
      rx = (m_owner == 1) ? r1 : r0;
      if (rx) begin
        m_vld  = 1'b1;
        m_data = (m_owner == 1) ? b : a;
        m_beats++;
        if (m_beats == BURST) begin
          m_last  = (m_owner == 1);
          m_owner = -1;
          m_beats = 0;
        end
      end else begin
        m_vld   = 1'b0;
        m_last  = (m_owner == 1);
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".gnt0"},       bus.gnt0,       m_owner == 0);
    check({tag, ".gnt1"},       bus.gnt1,       m_owner == 1);
    check({tag, ".sel"},        bus.sel,        m_sel);
    check({tag, ".out_valid"},  bus.out_valid,  m_vld);
    check({tag, ".out_data"},   bus.out_data,   m_data);
    check({tag, ".last_owner"}, bus.last_owner, m_last);
  endtask

  // Called just after a falling edge: drive, advance the model, then compare at the next falling edge.
  task automatic cycle(input string tag, input bit r0, input bit r1, input logic [3:0] a, input logic [3:0] b);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.d0   = a;
    bus.d1   = b;
    model_step(r0, r1, a, b);
    @(negedge sysclk);
    check_outputs(tag);
  endtask

  bit r0_s, r1_s;

  // Legal random requester behaviour: hold req until granted, may drop while owning.
  task automatic rand_cycle(input string tag);
    if (!r0_s)             r0_s = ($urandom_range(0, 2) == 0);
    else if (m_owner == 0) r0_s = ($urandom_range(0, 5) != 0);
    if (!r1_s)             r1_s = ($urandom_range(0, 2) == 0);
    else if (m_owner == 1) r1_s = ($urandom_range(0, 5) != 0);
    cycle(tag, r0_s, r1_s, 4'($urandom), 4'($urandom));
  endtask

  initial begin
    model_reset();
    sys_rst_n = 1'b0;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.d0    = 4'h5;
    bus.d1    = 4'h9;

    // Reset held with both requesting: nothing may move.
    repeat (3) begin
      @(negedge sysclk);
      check_outputs("rst_hold");
    end
    sys_rst_n = 1'b1;

    // Single requester, incrementing nibbles; burst then one idle then regrant.
    for (int i = 0; i < 12; i++) cycle("solo0", 1'b1, 1'b0, 4'(4'hA + i), 4'h0);
    cycle("solo_drop", 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("solo_idle", 1'b0, 1'b0, 4'h0, 4'h0);

    // Continuous contention: round-robin alternation (or fixed priority).
    for (int i = 0; i < 30; i++) cycle("contend", 1'b1, 1'b1, 4'(i), 4'(15 - i));

    // Owner 0 drops after two beats while req1 is waiting.
    cycle("drop_idle", 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("drop_idle", 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("drop_arb", 1'b1, 1'b1, 4'h1, 4'h8);
    cycle("drop_b1",  1'b1, 1'b1, 4'h2, 4'h8);
    cycle("drop_b2",  1'b1, 1'b1, 4'h3, 4'h8);
    cycle("drop_end", 1'b0, 1'b1, 4'h4, 4'h8);
    for (int i = 0; i < 4; i++) cycle("drop_next", 1'b0, 1'b1, 4'h0, 4'(8 + i));
    cycle("drop_tail", 1'b0, 1'b0, 4'h0, 4'h0);

    // Async reset mid-burst: outputs must clear without a clock edge.
    cycle("mid_arb", 1'b1, 1'b1, 4'h6, 4'h7);
    cycle("mid_b1",  1'b1, 1'b1, 4'h6, 4'h7);
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge sysclk);
    check_outputs("rst_low");
    sys_rst_n = 1'b1;
    cycle("post_rst", 1'b1, 1'b1, 4'hC, 4'h3);
    check("post_rst_first", bus.gnt0, 1'b1);

    // Randomized legal traffic.
    r0_s = 1'b1;
    r1_s = 1'b1;
    for (int i = 0; i < 2000; i++) rand_cycle("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
